// File: rtl/sat_add_pkg.sv
// sat_add_pkg: shared width default, saturation limits and response FSM encoding
package sat_add_pkg;
  localparam int WIDTH = 8;
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/sat_add_core.sv
// sat_add_core: combinational two's-complement saturating adder
module sat_add_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);
  logic [WIDTH:0] w_full;
  logic           w_pos_ovf;
  logic           w_neg_ovf;
  assign w_full    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  // The top two bits of the widened sum disagree exactly when the result leaves the signed range.
  assign w_pos_ovf = (w_full[WIDTH:WIDTH-1] == 2'b01);
  assign w_neg_ovf = (w_full[WIDTH:WIDTH-1] == 2'b10);
  assign sat       = w_pos_ovf | w_neg_ovf;
  assign sum       = w_pos_ovf ? {1'b0, {(WIDTH-1){1'b1}}} :
                     w_neg_ovf ? {1'b1, {(WIDTH-1){1'b0}}} : w_full[WIDTH-1:0];
endmodule

// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: round-robin sharing of one saturating adder with a registered, tagged response
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = sat_add_pkg::WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_sat
);
  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_idx;
  logic              w_found;
  logic              w_can_accept;
  logic              w_transfer;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_sum;
  logic              w_sat;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_sum;
  logic              r_sat;

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_can_accept = (r_state == EMPTY) || rsp_ready;
  assign req_ready    = (w_found && w_can_accept && rst_n) ? (N_REQ'(1) << w_winner) : '0;
  assign w_transfer   = |(req_valid & req_ready);
  assign w_a          = req_a[w_winner*WIDTH +: WIDTH];
  assign w_b          = req_b[w_winner*WIDTH +: WIDTH];

  sat_add_core #(.WIDTH(WIDTH)) u_core (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum),
    .sat (w_sat)
  );

  // Response slot: filled by any transfer, drained by rsp_ready, otherwise held.
  always_comb begin
    w_next = w_transfer ? FULL : (rsp_ready ? EMPTY : r_state);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  // Capture the winner's result and remember it for the next arbitration round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id         <= '0;
      r_sum        <= '0;
      r_sat        <= 1'b0;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_transfer) begin
      r_id         <= w_winner;
      r_sum        <= w_sum;
      r_sat        <= w_sat;
      r_last_grant <= w_winner;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_sat   = r_sat;
endmodule

// File: tb/tb_sat_add_arbiter.sv
// tb_sat_add_arbiter: vector table, directed sequences and randomized traffic against a reference model
module tb_sat_add_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [7:0]    rsp_sum;
  logic          rsp_sat;

  sat_add_arbiter #(.N_REQ(N), .WIDTH(8), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_sat   (rsp_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int req;
    int a;
    int b;
    int sum;
    int sat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit vv[N];
  int va[N];
  int vb[N];
  int m_last;
  bit m_full;
  int m_id;
  int m_sum;
  int m_sat;

  function automatic int ref_sum(input int a, input int b);
    int s;
    s = a + b;
    return (s > 127) ? 127 : ((s < -128) ? -128 : s);
  endfunction

  function automatic int ref_sat(input int a, input int b);
    return ((a + b) > 127 || (a + b) < -128) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rr);
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = vv[i];
      req_a[i*8 +: 8]  = 8'(va[i]);
      req_b[i*8 +: 8]  = 8'(vb[i]);
    end
    rsp_ready = rr;
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_full = 1'b0;
    m_id   = 0;
    m_sum  = 0;
    m_sat  = 0;
  endtask

  // One cycle: drive at the falling edge, check the grant, let the rising edge act, check the response.
  task automatic step(input bit rr);
    bit found;
    int w;
    int exp_ready;
    bit can;
    @(negedge clk);
    drive(rr);
    #1;
    found = 1'b0;
    w     = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && vv[(m_last + k) % N]) begin
        found = 1'b1;
        w     = (m_last + k) % N;
      end
    end
    can       = !m_full || rr;
    exp_ready = (found && can) ? (1 << w) : 0;
    chk("req_ready", int'(req_ready), exp_ready);
    @(posedge clk);
    if (found && can) begin
      m_full = 1'b1;
      m_id   = w;
      m_sum  = ref_sum(va[w], vb[w]);
      m_sat  = ref_sat(va[w], vb[w]);
      m_last = w;
      vv[w]  = 1'b0;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
    #1;
    chk("rsp_valid", int'(rsp_valid), int'(m_full));
    if (m_full) begin
      chk("rsp_id", int'(rsp_id), m_id);
      chk("rsp_sum", int'($signed(rsp_sum)), m_sum);
      chk("rsp_sat", int'(rsp_sat), m_sat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) vv[i] = 1'b0;
    drive(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[8];
  int   held_id;
  int   held_sum;
  int   held_sat;

  initial begin
    tbl[0] = '{req: 0, a: 3,    b: 3,    sum: 6,    sat: 0};
    tbl[1] = '{req: 1, a: -127, b: -128, sum: -128, sat: 1};
    tbl[2] = '{req: 2, a: 97,   b: 96,   sum: 127,  sat: 1};
    tbl[3] = '{req: 3, a: 127,  b: 0,    sum: 127,  sat: 0};
    tbl[4] = '{req: 0, a: -128, b: 0,    sum: -128, sat: 0};
    tbl[5] = '{req: 1, a: 127,  b: 1,    sum: 127,  sat: 1};
    tbl[6] = '{req: 2, a: -1,   b: -128, sum: -128, sat: 1};
    tbl[7] = '{req: 3, a: -100, b: 50,   sum: -50,  sat: 0};

    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      vv[i] = 1'b1;
      va[i] = i;
      vb[i] = i;
    end
    drive(1'b1);
    #12;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_sum", int'(rsp_sum), 0);
    chk("reset_rsp_sat", int'(rsp_sat), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    do_reset();

    for (int t = 0; t < 8; t++) begin
      vv[tbl[t].req] = 1'b1;
      va[tbl[t].req] = tbl[t].a;
      vb[tbl[t].req] = tbl[t].b;
      step(1'b1);
      chk("tbl_sum", int'($signed(rsp_sum)), tbl[t].sum);
      chk("tbl_sat", int'(rsp_sat), tbl[t].sat);
      chk("tbl_id", int'(rsp_id), tbl[t].req);
      step(1'b1);
    end

    do_reset();
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < N; i++) begin
        vv[i] = 1'b1;
        va[i] = 10 * i + s;
        vb[i] = -3 * i;
      end
      step(1'b1);
      chk("rr_id", int'(rsp_id), s % N);
      chk("rr_valid", int'(rsp_valid), 1);
    end

    held_id  = int'(rsp_id);
    held_sum = int'(rsp_sum);
    held_sat = int'(rsp_sat);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < N; i++) vv[i] = 1'b1;
      step(1'b0);
      chk("bp_id", int'(rsp_id), held_id);
      chk("bp_sum", int'(rsp_sum), held_sum);
      chk("bp_sat", int'(rsp_sat), held_sat);
    end
    step(1'b1);
    chk("bp_next_id", int'(rsp_id), 1);
    step(1'b1);
    chk("bp_b2b_id", int'(rsp_id), 2);
    chk("bp_b2b_valid", int'(rsp_valid), 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", int'(rsp_valid), 0);
    chk("async_req_ready", int'(req_ready), 0);
    model_reset();
    for (int i = 0; i < N; i++) vv[i] = (i == 1 || i == 2);
    va[1] = 5;
    vb[1] = 6;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    chk("post_reset_id", int'(rsp_id), 1);
    chk("post_reset_sum", int'($signed(rsp_sum)), 11);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vv[i] && $urandom_range(0, 2) == 0) begin
          vv[i] = 1'b1;
          va[i] = int'($urandom_range(0, 255)) - 128;
          vb[i] = int'($urandom_range(0, 255)) - 128;
        end
      end
      step($urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
